// File: rtl/sat_cntr_pkg.sv
// Shared definitions for the saturating/wrapping counter family:
// overflow-mode encodings, next-count source selection and a range clamp.
package sat_cntr_pkg;

  // Overflow behaviour selected by the wrap_mode input.
  localparam logic MODE_SAT  = 1'b0;
  localparam logic MODE_WRAP = 1'b1;

  // Widest value the shared clamp handles; counters up to this width use it.
  localparam int CLAMP_W = 32;

  // Which rule produces the next count value this cycle.
  typedef enum logic [1:0] {
    SRC_HOLD = 2'd0,
    SRC_LOAD = 2'd1,
    SRC_FIX  = 2'd2,
    SRC_STEP = 2'd3
  } cnt_src_e;

  // Clamp value into [lo, hi]; callers zero-extend narrower operands.
  function automatic logic [CLAMP_W-1:0] clamp(
    input logic [CLAMP_W-1:0] value,
    input logic [CLAMP_W-1:0] lo,
    input logic [CLAMP_W-1:0] hi
  );
    if (value < lo) begin
      return lo;
    end else if (value > hi) begin
      return hi;
    end else begin
      return value;
    end
  endfunction

endpackage

// File: rtl/sat_updown_cntr_step_calc.sv
// Combinational step arithmetic: next count and limit-hit event for one
// up/down step against the [min, max] window, in saturate or wrap mode.
// Assumes cnt_i already lies inside the window (the top corrects it first).
module sat_step_calc
  import sat_cntr_pkg::*;
#(
  parameter int N      = 8,
  parameter int STEP_W = 4
) (
  input  logic [N-1:0]      cnt_i,
  input  logic [STEP_W-1:0] step_i,
  input  logic              up_i,
  input  logic [N-1:0]      min_i,
  input  logic [N-1:0]      max_i,
  input  logic              wrap_mode_i,
  output logic [N-1:0]      next_cnt_o,
  output logic              sat_evt_o
);

  // One guard bit above the wider operand so a sum can never alias.
  localparam int AW = ((N > STEP_W) ? N : STEP_W) + 1;

  logic [AW-1:0] cnt_x;
  logic [AW-1:0] step_x;
  logic [AW-1:0] min_x;
  logic [AW-1:0] max_x;
  logic [AW-1:0] sum_x;
  logic [AW-1:0] room_x;
  logic [AW-1:0] diff_x;
  logic          wrap;

  assign cnt_x  = AW'(cnt_i);
  assign step_x = AW'(step_i);
  assign min_x  = AW'(min_i);
  assign max_x  = AW'(max_i);
  assign sum_x  = cnt_x + step_x;
  assign room_x = cnt_x - min_x;   // distance down to the floor
  assign diff_x = cnt_x - step_x;
  assign wrap   = (wrap_mode_i == MODE_WRAP);

  // Pick the stepped value, or the limit (own or opposite) when the step overshoots.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    next_cnt_o = cnt_i;
    sat_evt_o  = 1'b0;
    if (step_x != '0) begin
      if (up_i) begin
        if (sum_x > max_x) begin
          sat_evt_o  = 1'b1;
          next_cnt_o = wrap ? min_i : max_i;
        end else begin
          next_cnt_o = N'(sum_x);
        end
      end else begin
        if (step_x > room_x) begin
          sat_evt_o  = 1'b1;
          next_cnt_o = wrap ? max_i : min_i;
        end else begin
          next_cnt_o = N'(diff_x);
        end
      end
    end
  end

endmodule

// File: rtl/sat_updown_cntr.sv
// Up/down counter with programmable step, runtime [min, max] limits,
// saturate or wrap overflow, synchronous load, saturation pulse/sticky
// flags and rejected-limit-write reporting. N must not exceed CLAMP_W.
module sat_updown_cntr
  import sat_cntr_pkg::*;
#(
  parameter int            N       = 8,
  parameter int            STEP_W  = 4,
  parameter logic [N-1:0]  MIN_DEF = '0,
  parameter logic [N-1:0]  MAX_DEF = '1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              up,
  input  logic [STEP_W-1:0] step,
  input  logic              wrap_mode,
  input  logic              load,
  input  logic [N-1:0]      load_val,
  input  logic              lim_we,
  input  logic [N-1:0]      lim_min,
  input  logic [N-1:0]      lim_max,
  input  logic              clr_sticky,
  output logic [N-1:0]      cnt,
  output logic              at_max,
  output logic              at_min,
  output logic              sat_pulse,
  output logic              sat_sticky,
  output logic              lim_err
);

  logic [N-1:0] cnt_q,  cnt_d;
  logic [N-1:0] min_q,  min_d;
  logic [N-1:0] max_q,  max_d;
  logic         sat_pulse_q, sat_pulse_d;
  logic         sat_sticky_q, sat_sticky_d;
  logic         lim_err_q,   lim_err_d;

  cnt_src_e     src;
  logic         out_of_range;
  logic         load_outside;
  logic [N-1:0] load_clamped;
  logic [N-1:0] cnt_clamped;
  logic [N-1:0] step_cnt;
  logic         step_evt;
  logic         lim_ok;
  logic         sat_evt;

  assign out_of_range = (cnt_q < min_q) || (cnt_q > max_q);
  assign load_outside = (load_val < min_q) || (load_val > max_q);
  assign load_clamped = N'(clamp(CLAMP_W'(load_val), CLAMP_W'(min_q), CLAMP_W'(max_q)));
  assign cnt_clamped  = N'(clamp(CLAMP_W'(cnt_q), CLAMP_W'(min_q), CLAMP_W'(max_q)));
  assign lim_ok       = (lim_min <= lim_max);

  sat_step_calc #(
    .N      (N),
    .STEP_W (STEP_W)
  ) u_step_calc (
    .cnt_i       (cnt_q),
    .step_i      (step),
    .up_i        (up),
    .min_i       (min_q),
    .max_i       (max_q),
    .wrap_mode_i (wrap_mode),
    .next_cnt_o  (step_cnt),
    .sat_evt_o   (step_evt)
  );

  // Priority decode: load beats range correction beats counting.
  always_comb begin
    src = SRC_HOLD;
    if (load) begin
      src = SRC_LOAD;
    end else if (out_of_range) begin
      src = SRC_FIX;
    end else if (en) begin
      src = SRC_STEP;
    end
  end

  // Next count and saturation event from the selected source (old limits apply).
  always_comb begin
    cnt_d   = cnt_q;
    sat_evt = 1'b0;
    unique case (src)
      SRC_LOAD: begin
        cnt_d   = load_clamped;
        sat_evt = load_outside;
      end
      SRC_FIX:  cnt_d = cnt_clamped;
      SRC_STEP: begin
        cnt_d   = step_cnt;
        sat_evt = step_evt;
      end
      default:  cnt_d = cnt_q;
    endcase
  end

  // Limit writes land only when ordered; a reversed pair is dropped and flagged.
  always_comb begin
    min_d     = min_q;
    max_d     = max_q;
    lim_err_d = 1'b0;
    if (lim_we) begin
      if (lim_ok) begin
        min_d = lim_min;
        max_d = lim_max;
      end else begin
        lim_err_d = 1'b1;
      end
    end
  end

  // Event flags: a new event outranks a simultaneous sticky clear.
  always_comb begin
    sat_pulse_d  = sat_evt;
    sat_sticky_d = sat_evt | (sat_sticky_q & ~clr_sticky);
  end

  // State registers with synchronous reset to the default window.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers sample together.
    if (reset) begin
      cnt_q        <= MIN_DEF;
      min_q        <= MIN_DEF;
      max_q        <= MAX_DEF;
      sat_pulse_q  <= 1'b0;
      sat_sticky_q <= 1'b0;
      lim_err_q    <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      min_q        <= min_d;
      max_q        <= max_d;
      sat_pulse_q  <= sat_pulse_d;
      sat_sticky_q <= sat_sticky_d;
      lim_err_q    <= lim_err_d;
    end
  end

  assign cnt        = cnt_q;
  assign at_max     = (cnt_q == max_q);
  assign at_min     = (cnt_q == min_q);
  assign sat_pulse  = sat_pulse_q;
  assign sat_sticky = sat_sticky_q;
  assign lim_err    = lim_err_q;

endmodule

// File: tb/tb_sat_updown_cntr.sv
// Directed bench for sat_updown_cntr (N=8, STEP_W=4, defaults [0,255]).
// Inputs change #1 after a rising edge; outputs are checked there too.
module tb_sat_updown_cntr;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic       up;
  logic [3:0] step;
  logic       wrap_mode;
  logic       load;
  logic [7:0] load_val;
  logic       lim_we;
  logic [7:0] lim_min;
  logic [7:0] lim_max;
  logic       clr_sticky;
  logic [7:0] cnt;
  logic       at_max;
  logic       at_min;
  logic       sat_pulse;
  logic       sat_sticky;
  logic       lim_err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sat_updown_cntr #(
    .N       (8),
    .STEP_W  (4),
    .MIN_DEF (8'd0),
    .MAX_DEF (8'd255)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .up         (up),
    .step       (step),
    .wrap_mode  (wrap_mode),
    .load       (load),
    .load_val   (load_val),
    .lim_we     (lim_we),
    .lim_min    (lim_min),
    .lim_max    (lim_max),
    .clr_sticky (clr_sticky),
    .cnt        (cnt),
    .at_max     (at_max),
    .at_min     (at_min),
    .sat_pulse  (sat_pulse),
    .sat_sticky (sat_sticky),
    .lim_err    (lim_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reset = 1'b0; en = 1'b0; up = 1'b1; step = 4'd0; wrap_mode = 1'b0;
    load = 1'b0; load_val = 8'd0; lim_we = 1'b0; lim_min = 8'd0;
    lim_max = 8'd0; clr_sticky = 1'b0;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    check("rst_cnt", cnt, 0);
    check("rst_at_min", at_min, 1);
    check("rst_at_max", at_max, 0);
    check("rst_pulse", sat_pulse, 0);
    check("rst_sticky", sat_sticky, 0);
    check("rst_lim_err", lim_err, 0);

    // Count up by 1 for 260 cycles: 1..255 then hold with a pulse per attempt.
    en = 1'b1; up = 1'b1; step = 4'd1;
    for (int k = 1; k <= 260; k++) begin
      tick();
      check("up_cnt", cnt, (k > 255) ? 255 : k);
      check("up_pulse", sat_pulse, (k >= 256) ? 1 : 0);
    end
    check("up_at_max", at_max, 1);
    check("up_sticky", sat_sticky, 1);

    // New window [10,20]; count of 255 is pulled to 20 one cycle later.
    idle();
    lim_we = 1'b1; lim_min = 8'd10; lim_max = 8'd20;
    tick();
    lim_we = 1'b0;
    check("limw_cnt_old", cnt, 255);
    check("limw_pulse", sat_pulse, 0);
    tick();
    check("fix_cnt", cnt, 20);
    check("fix_pulse", sat_pulse, 0);
    check("fix_at_max", at_max, 1);

    // Wrap mode: 18 + 5 overshoots -> min; 10 - 3 undershoots -> max.
    load = 1'b1; load_val = 8'd18;
    tick();
    load = 1'b0;
    check("ld18_cnt", cnt, 18);
    check("ld18_pulse", sat_pulse, 0);
    wrap_mode = 1'b1; en = 1'b1; up = 1'b1; step = 4'd5;
    tick();
    check("wrap_up_cnt", cnt, 10);
    check("wrap_up_pulse", sat_pulse, 1);
    up = 1'b0; step = 4'd3;
    tick();
    check("wrap_dn_cnt", cnt, 20);
    check("wrap_dn_pulse", sat_pulse, 1);

    // Saturate mode: exact reach of min is no event, one more step is.
    idle();
    load = 1'b1; load_val = 8'd12;
    tick();
    load = 1'b0;
    check("ld12_cnt", cnt, 12);
    en = 1'b1; up = 1'b0; step = 4'd2;
    tick();
    check("sat_exact_cnt", cnt, 10);
    check("sat_exact_pulse", sat_pulse, 0);
    check("sat_exact_at_min", at_min, 1);
    step = 4'd1;
    tick();
    check("sat_dn_cnt", cnt, 10);
    check("sat_dn_pulse", sat_pulse, 1);
    // Exact reach of max going up.
    en = 1'b0; load = 1'b1; load_val = 8'd15;
    tick();
    load = 1'b0; en = 1'b1; up = 1'b1; step = 4'd5;
    tick();
    check("sat_up_exact_cnt", cnt, 20);
    check("sat_up_exact_pulse", sat_pulse, 0);
    // en with step 0 at the limit: hold, no event.
    step = 4'd0;
    tick();
    check("step0_cnt", cnt, 20);
    check("step0_pulse", sat_pulse, 0);

    // Reversed limit write is rejected for exactly one cycle.
    idle();
    lim_we = 1'b1; lim_min = 8'd30; lim_max = 8'd5;
    tick();
    lim_we = 1'b0;
    check("bad_lim_err", lim_err, 1);
    check("bad_lim_at_max", at_max, 1);
    tick();
    check("bad_lim_err_clr", lim_err, 0);
    check("bad_lim_cnt", cnt, 20);

    // Shrink the window under cnt=100: corrected to 7, no event.
    lim_we = 1'b1; lim_min = 8'd0; lim_max = 8'd255;
    tick();
    lim_we = 1'b0; load = 1'b1; load_val = 8'd100;
    tick();
    load = 1'b0;
    check("ld100_cnt", cnt, 100);
    lim_we = 1'b1; lim_min = 8'd0; lim_max = 8'd7;
    tick();
    lim_we = 1'b0;
    check("shrink_cnt_old", cnt, 100);
    check("shrink_lim_err", lim_err, 0);
    tick();
    check("shrink_cnt", cnt, 7);
    check("shrink_pulse", sat_pulse, 0);
    check("shrink_at_max", at_max, 1);

    // Clamped load into [10,20] with a same-cycle sticky clear.
    lim_we = 1'b1; lim_min = 8'd10; lim_max = 8'd20;
    tick();
    lim_we = 1'b0;
    tick();
    check("widen_cnt", cnt, 10);
    load = 1'b1; load_val = 8'd200; clr_sticky = 1'b1;
    tick();
    load = 1'b0;
    check("ld200_cnt", cnt, 20);
    check("ld200_pulse", sat_pulse, 1);
    check("ld200_sticky", sat_sticky, 1);
    tick();
    clr_sticky = 1'b0;
    check("clr_sticky", sat_sticky, 0);
    check("clr_pulse", sat_pulse, 0);

    // Pinned window [15,15]: any nonzero step is an event.
    lim_we = 1'b1; lim_min = 8'd15; lim_max = 8'd15;
    tick();
    lim_we = 1'b0;
    tick();
    check("pin_cnt_fix", cnt, 15);
    en = 1'b1; up = 1'b1; step = 4'd1;
    tick();
    check("pin_cnt", cnt, 15);
    check("pin_pulse", sat_pulse, 1);
    check("pin_sticky", sat_sticky, 1);

    // Reset overrides same-cycle load, limit write and counting.
    load = 1'b1; load_val = 8'd3; lim_we = 1'b1; lim_min = 8'd1; lim_max = 8'd2;
    reset = 1'b1;
    tick();
    idle();
    check("mid_rst_cnt", cnt, 0);
    check("mid_rst_at_min", at_min, 1);
    check("mid_rst_pulse", sat_pulse, 0);
    check("mid_rst_sticky", sat_sticky, 0);
    check("mid_rst_lim_err", lim_err, 0);
    load = 1'b1; load_val = 8'd255;
    tick();
    load = 1'b0;
    check("post_rst_cnt", cnt, 255);
    check("post_rst_at_max", at_max, 1);
    check("post_rst_pulse", sat_pulse, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sat_updown_cntr.md
Name: sat_updown_cntr

Overview:
- Parametrised N-bit up/down counter with a programmable step and runtime-programmable [min,max] limits.
- Two overflow modes:
  - saturate: clamp at the limit.
  - wrap: roll over to the opposite limit.
- Adds synchronous load, saturation event/sticky flags and limit-error reporting.
- General-purpose event/credit/level counter for control paths; successor to the fixed-limit up-only saturating counter.

Parameters:
- N, 8, counter width in bits.
- STEP_W, 4, width of the step input.
- MIN_DEF, 0, reset value of the min limit register.
- MAX_DEF, 2**N-1, reset value of the max limit register. Must satisfy MIN_DEF <= MAX_DEF < 2**N.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- en  in  1  count enable for this cycle.
- up  in  1  direction: 1 = add step, 0 = subtract step.
- step  in  STEP_W  unsigned increment magnitude.
- wrap_mode  in  1  0 = saturate, 1 = wrap to opposite limit.
- load  in  1  synchronous load of load_val.
- load_val  in  N  value to load.
- lim_we  in  1  write new limits.
- lim_min  in  N  new min limit.
- lim_max  in  N  new max limit.
- clr_sticky  in  1  clear sat_sticky.
- cnt  out  N  counter value (registered).
- at_max  out  1  cnt == max_r (combinational from registers).
- at_min  out  1  cnt == min_r (combinational from registers).
- sat_pulse  out  1  registered one-cycle pulse: the previous cycle's operation hit a limit.
- sat_sticky  out  1  sticky saturation flag.
- lim_err  out  1  registered one-cycle pulse: rejected limit write.

Behaviour:
- Interface: reset reset, synchronous, active-high; clock clk.
- Reset values: cnt=MIN_DEF, min_r=MIN_DEF, max_r=MAX_DEF, sat_pulse=0, sat_sticky=0, lim_err=0.
- Latency: all register updates occur at the rising edge after the inputs are sampled. cnt reflects an operation one cycle later.
- cnt next-state priority, evaluated against the current min_r/max_r:
  1. reset.
  2. load: cnt <= clamp(load_val, min_r, max_r). Sets the saturation event if load_val lies outside the range. This holds in both modes; load never wraps.
  3. Out-of-range correction: if cnt < min_r or cnt > max_r, then cnt <= clamp(cnt). No saturation event. Counting is suppressed this cycle.
  4. en with step != 0, with arithmetic done at N+1 bits (zero-extended):
     - up: t = cnt + step. If t > max_r, the event fires and cnt <= max_r (saturate) or min_r (wrap). Otherwise cnt <= t.
     - down: if step > cnt - min_r, the event fires and cnt <= min_r (saturate) or max_r (wrap). Otherwise cnt <= cnt - step.
     - Exactly reaching a limit is not an event.
  5. Otherwise hold. en with step == 0 holds with no event.
- Limit writes:
  - lim_we with lim_min <= lim_max: min_r/max_r update at the edge. The count operation in the same cycle uses the old limits. If cnt falls outside the new range, it is corrected next cycle by rule 3.
  - lim_we with lim_min > lim_max: write ignored, lim_err=1 for one cycle.
- Wrap mode is a roll-over to the opposite limit with no residue carried.
- sat_pulse <= saturation event of the current cycle.
- sat_sticky <= event | (sat_sticky & ~clr_sticky). Set wins over a simultaneous clear.
- min_r == max_r is legal. The counter is then pinned, and any nonzero step with en is an event.
- Reset mid-operation overrides load, limit writes and counting in the same cycle.

Decomposition:
- Package sat_cntr_pkg: mode constants MODE_SAT=1'b0 and MODE_WRAP=1'b1, plus a clamp function (value, lo, hi) shared with other counters.
- One natural sub-module, sat_step_calc (combinational):
  - Inputs: cnt, step, up, min_r, max_r, wrap_mode.
  - Outputs: next count and event flag.
  - Lets the event arithmetic be unit-tested separately.
- The top level holds the registers, priority mux and flags.

Test Plan:
- Reset, then en=1 up=1 step=1 for 260 cycles (N=8): cnt counts 0..255 and then holds at 255. at_max=1 from cnt=255. One sat_pulse per attempted overflow cycle. sat_sticky=1.
- Load limits min=10 max=20, load 18, wrap_mode=1, up step=5: cnt becomes 10 with sat_pulse. Then down step=3 from 10: cnt becomes 20 with sat_pulse.
- Saturate mode, limits min=10 max=20, cnt=12, down step=2: cnt=10, no sat_pulse. Next down step=1: cnt stays 10 with sat_pulse.
- lim_we with min=30 max=5: lim_err pulses once, limits unchanged. Then lim_we min=0 max=7 while cnt=100: next cycle cnt=7, no sat_pulse.
- Load 200 with limits [10,20]: cnt=20 and sat_pulse. clr_sticky in the same cycle as a new event: sat_sticky stays 1. clr_sticky alone: sat_sticky=0.
- Assert reset during a same-cycle load and en: cnt=MIN_DEF, limits back to defaults, all flags 0.
